// File: rtl/mem_access_ctrl_if.sv
// Request, memory and pipeline-control signals between the MEM stage, the
// data memory and mem_access_ctrl. The controller uses the master modport.
`timescale 1ns/1ps
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              halt_req;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;
  logic              mem_done;
  logic              stall_out;
  logic [DATA_W-1:0] rdata_out;
  logic              rdata_valid;
  logic              dump;
  logic              halted;
  logic              err;

  modport master (
    input  req_rd, req_wr, req_addr, req_wdata, halt_req,
    input  mem_rdata, mem_stall, mem_done,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output stall_out, rdata_out, rdata_valid, dump, halted, err
  );

  modport slave (
    output req_rd, req_wr, req_addr, req_wdata, halt_req,
    output mem_rdata, mem_stall, mem_done,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  stall_out, rdata_out, rdata_valid, dump, halted, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences MEM-stage loads/stores onto a multi-cycle data memory, stalls the
// pipeline while an access is in flight, and handles halt dump and error stop.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  mem_access_ctrl_if.master bus
);
  localparam int unsigned    CNT_W    = ($clog2(TIMEOUT) < 4) ? 4 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DUMP, S_HALTED, S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_kind_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_rvalid;
  logic              r_dump;
  logic              r_halted;
  logic              r_err;

  logic w_req;
  logic w_bad;
  logic w_capture;
  logic w_finish;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_stall;
  logic w_kind_rd;

  // Next-state and per-cycle control decode
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_finish  = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_stall   = 1'b0;
    w_req     = bus.req_rd | bus.req_wr;
    w_bad     = (bus.req_rd & bus.req_wr) | (w_req & bus.req_addr[0]);
    unique case (r_state)
      S_IDLE: begin
        if (w_bad) begin
          w_next = S_ERR;
        end else if (w_req) begin
          w_next    = S_ISSUE;
          w_capture = 1'b1;
          w_stall   = 1'b1;
        end else if (bus.halt_req) begin
          w_next = S_DUMP;
        end
      end
      S_ISSUE: begin
        w_stall = 1'b1;
        if (!bus.mem_stall) begin
          if (bus.mem_done) begin
            w_next   = S_DONE;
            w_finish = 1'b1;
          end else begin
            w_next    = S_WAIT;
            w_cnt_clr = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (bus.mem_done) begin
          w_next   = S_DONE;
          w_finish = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_next = S_ERR;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DONE:   w_next = S_IDLE;
      S_DUMP:   w_next = S_HALTED;
      S_HALTED: w_next = S_HALTED;
      S_ERR:    w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
    w_kind_rd = w_capture ? bus.req_rd : r_kind_rd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kind_rd <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
      r_mem_rd  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_dump    <= 1'b0;
      r_halted  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_kind_rd <= bus.req_rd;
        r_addr    <= bus.req_addr;
        r_wdata   <= bus.req_wdata;
      end
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_finish && r_kind_rd) r_rdata <= bus.mem_rdata;
      r_mem_rd <= (w_next == S_ISSUE) && w_kind_rd;
      r_mem_wr <= (w_next == S_ISSUE) && !w_kind_rd;
      r_rvalid <= w_finish && r_kind_rd;
      r_dump   <= (w_next == S_DUMP);
      r_err    <= r_err || (w_next == S_ERR);
      r_halted <= r_halted || (w_next == S_ERR) || (w_next == S_HALTED);
    end
  end

  assign bus.mem_rd      = r_mem_rd;
  assign bus.mem_wr      = r_mem_wr;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.rdata_out   = r_rdata;
  assign bus.rdata_valid = r_rvalid;
  assign bus.dump        = r_dump;
  assign bus.halted      = r_halted;
  assign bus.err         = r_err;
  // Combinational so the pipeline freezes in the same cycle a request appears
  assign bus.stall_out   = w_stall & rst;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level reference: one outstanding access, retire/dump cycles, stop flag
  bit          m_acc, m_strobe, m_kind_rd, m_retire, m_dump, m_stopped, m_err;
  int          m_wait;
  logic [15:0] m_addr  = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;

  task automatic m_fail();
    m_acc = 0; m_strobe = 0; m_stopped = 1; m_err = 1;
  endtask

  task automatic m_finish();
    m_acc = 0; m_strobe = 0; m_retire = 1;
    if (m_kind_rd) m_rdata = bus.mem_rdata;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acc = 0; m_strobe = 0; m_kind_rd = 0; m_retire = 0; m_dump = 0;
      m_stopped = 0; m_err = 0; m_wait = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_dump) begin
      m_dump = 0; m_stopped = 1;
    end else if (m_retire) begin
      m_retire = 0;
    end else if (m_acc) begin
      if (m_strobe) begin
        if (!bus.mem_stall) begin
          if (bus.mem_done) m_finish();
          else begin m_strobe = 0; m_wait = 0; end
        end
      end else if (bus.mem_done) begin
        m_finish();
      end else if (m_wait + 1 == int'(TIMEOUT)) begin
        m_fail();
      end else begin
        m_wait++;
      end
    end else if (!m_stopped) begin
      if ((bus.req_rd && bus.req_wr) || ((bus.req_rd || bus.req_wr) && bus.req_addr[0]))
        m_fail();
      else if (bus.req_rd || bus.req_wr) begin
        m_acc = 1; m_strobe = 1; m_kind_rd = bus.req_rd;
        m_addr = bus.req_addr; m_wdata = bus.req_wdata;
      end else if (bus.halt_req) begin
        m_dump = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic legal;
    legal = (bus.req_rd ^ bus.req_wr) && !bus.req_addr[0];
    chk("mem_rd",      bus.mem_rd,      m_acc && m_strobe && m_kind_rd);
    chk("mem_wr",      bus.mem_wr,      m_acc && m_strobe && !m_kind_rd);
    chk("mem_addr",    bus.mem_addr,    m_addr);
    chk("mem_wdata",   bus.mem_wdata,   m_wdata);
    chk("stall_out",   bus.stall_out,   rst && !m_stopped && !m_dump && !m_retire && (m_acc || legal));
    chk("rdata_valid", bus.rdata_valid, m_retire && m_kind_rd);
    chk("rdata_out",   bus.rdata_out,   m_rdata);
    chk("dump",        bus.dump,        m_dump);
    chk("halted",      bus.halted,      m_stopped);
    chk("err",         bus.err,         m_err);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.req_rd = 0; bus.req_wr = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.halt_req = 0; bus.mem_rdata = '0; bus.mem_stall = 0; bus.mem_done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wr_cycles, strobes, dumps, release_cyc;
    bit rv_seen;
    idle_inputs();
    #1 rst = 0;
    #2;
    chk("reset_mem_rd", bus.mem_rd, 0);
    chk("reset_halted", bus.halted, 0);
    chk("reset_rdata",  bus.rdata_out, 0);
    do_reset();

    // Load 0x0010, done in ISSUE
    bus.req_rd = 1; bus.req_addr = 16'h0010;
    #1 chk("t1_stall_c0", bus.stall_out, 1);
    step();
    bus.mem_done = 1; bus.mem_rdata = 16'hBEEF;
    #1 chk("t1_mem_rd_c1", bus.mem_rd, 1);
    chk("t1_stall_c1", bus.stall_out, 1);
    chk("t1_addr_c1", bus.mem_addr, 16'h0010);
    step();
    bus.req_rd = 0; bus.mem_done = 0;
    #1 chk("t1_rvalid_c2", bus.rdata_valid, 1);
    chk("t1_rdata_c2", bus.rdata_out, 16'hBEEF);
    chk("t1_stall_c2", bus.stall_out, 0);
    step();

    // Store 0x1234 @0x0020: two stall cycles, then two WAIT cycles before done
    bus.req_wr = 1; bus.req_addr = 16'h0020; bus.req_wdata = 16'h1234;
    wr_cycles = 0; rv_seen = 0; release_cyc = -1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      bus.mem_stall = (cyc <= 2);
      bus.mem_done  = (cyc == 5);
      bus.req_wr    = (cyc < 6);
      #1;
      if (bus.mem_wr) begin
        wr_cycles++;
        chk("t2_wdata", bus.mem_wdata, 16'h1234);
      end
      rv_seen |= bus.rdata_valid;
      if (!bus.stall_out && release_cyc < 0) release_cyc = cyc;
    end
    chk("t2_wr_cycles", wr_cycles, 3);
    chk("t2_rvalid", rv_seen, 0);
    chk("t2_release", release_cyc, 6);

    // Unaligned load, then later requests ignored
    do_reset();
    bus.req_rd = 1; bus.req_addr = 16'h0011;
    #1 chk("t3_stall_bad", bus.stall_out, 0);
    step();
    #1 chk("t3_err", bus.err, 1);
    chk("t3_halted", bus.halted, 1);
    strobes = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.req_rd = 1; bus.req_addr = 16'h0040; bus.mem_done = 1;
      step();
      #1 strobes += int'(bus.mem_rd) + int'(bus.mem_wr);
    end
    chk("t3_strobes", strobes, 0);
    chk("t3_err_sticky", bus.err, 1);

    // Read and write together
    do_reset();
    bus.req_rd = 1; bus.req_wr = 1; bus.req_addr = 16'h0040;
    strobes = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step();
      #1 strobes += int'(bus.mem_rd) + int'(bus.mem_wr);
    end
    chk("t3b_strobes", strobes, 0);
    chk("t3b_err", bus.err, 1);

    // Load with no done: 15 WAIT cycles then ERR
    do_reset();
    bus.req_rd = 1; bus.req_addr = 16'h0004;
    step();
    repeat (15) step();
    #1 chk("t4_err_c16", bus.err, 0);
    chk("t4_stall_c16", bus.stall_out, 1);
    step();
    #1 chk("t4_err_c17", bus.err, 1);
    chk("t4_halted_c17", bus.halted, 1);
    chk("t4_stall_c17", bus.stall_out, 0);

    // Halt together with a load
    do_reset();
    bus.req_rd = 1; bus.halt_req = 1; bus.req_addr = 16'h0008;
    step();
    bus.mem_done = 1; bus.mem_rdata = 16'h5A5A;
    #1 chk("t5_mem_rd_c1", bus.mem_rd, 1);
    step();
    bus.req_rd = 0; bus.mem_done = 0;
    #1 chk("t5_rvalid_c2", bus.rdata_valid, 1);
    chk("t5_rdata_c2", bus.rdata_out, 16'h5A5A);
    step();
    #1 chk("t5_dump_c3", bus.dump, 0);
    dumps = 0;
    for (int cyc = 4; cyc <= 9; cyc++) begin
      step();
      bus.req_rd = (cyc >= 6); bus.req_addr = 16'h000A;
      #1 dumps += int'(bus.dump);
      if (cyc == 4) chk("t5_dump_c4", bus.dump, 1);
      if (cyc == 5) chk("t5_halted_c5", bus.halted, 1);
      if (cyc == 7) chk("t5_stall_c7", bus.stall_out, 0);
      if (cyc == 8) chk("t5_mem_rd_c8", bus.mem_rd, 0);
    end
    chk("t5_dump_count", dumps, 1);

    // Async reset during ISSUE drops the strobe
    do_reset();
    bus.req_rd = 1; bus.req_addr = 16'h0006;
    step();
    bus.mem_stall = 1;
    #1 chk("t6_mem_rd_issue", bus.mem_rd, 1);
    rst = 0;
    #1 chk("t6_mem_rd_rst", bus.mem_rd, 0);
    chk("t6_stall_rst_issue", bus.stall_out, 0);
    do_reset();

    // Async reset mid-WAIT
    bus.req_rd = 1; bus.req_addr = 16'h0006;
    step();
    step();
    step();
    #1 chk("t6_stall_wait", bus.stall_out, 1);
    rst = 0;
    #1 chk("t6_stall_rst", bus.stall_out, 0);
    chk("t6_rvalid_rst", bus.rdata_valid, 0);
    chk("t6_err_rst", bus.err, 0);
    do_reset();
    bus.req_rd = 1; bus.req_addr = 16'h0002;
    step();
    bus.mem_done = 1; bus.mem_rdata = 16'hCAFE;
    step();
    bus.req_rd = 0; bus.mem_done = 0;
    #1 chk("t6_rvalid_after", bus.rdata_valid, 1);
    chk("t6_rdata_after", bus.rdata_out, 16'hCAFE);

    // Randomized traffic; every eighth episode never returns done
    for (int ep = 0; ep < 40; ep++) begin
      int unsigned done_pct;
      done_pct = (ep % 8 == 7) ? 0 : 35;
      do_reset();
      for (int c = 0; c < 80; c++) begin
        int unsigned r;
        logic [15:0] a;
        r = $urandom_range(0, 99);
        a = 16'($urandom);
        if ($urandom_range(0, 39) != 0) a[0] = 1'b0;
        bus.req_rd    = (r < 13) || (r == 99);
        bus.req_wr    = (r >= 13 && r < 25) || (r == 99);
        bus.req_addr  = a;
        bus.req_wdata = 16'($urandom);
        bus.halt_req  = ($urandom_range(0, 59) == 0);
        bus.mem_stall = ($urandom_range(0, 99) < 30);
        bus.mem_done  = ($urandom_range(0, 99) < done_pct);
        bus.mem_rdata = 16'($urandom);
        step();
      end
    end

    idle_inputs();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
